// File: rtl/servo_pwm_decoder_pkg.sv
// Shared constants and types for the servo PWM receive path.
package servo_pkg;
    localparam int CLK_FREQ_HZ         = 50_000_000;
    localparam int SERVO_MIN_PULSE_CYC = 50_000;
    localparam int SERVO_MAX_PULSE_CYC = 100_000;
    localparam int SERVO_PERIOD_CYC    = 1_000_000;
    localparam int SERVO_TIMEOUT_CYC   = 1_250_000;
    localparam int ANGLE_MAX           = 180;

    typedef logic [7:0] angle_t;

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

    typedef enum logic [1:0] {DIV_IDLE, DIV_NUM, DIV_ITER, DIV_OUT} div_phase_t;
endpackage

// File: rtl/servo_pwm_decoder_if.sv
// PWM line in, decoded angle and status out; master drives the line, slave decodes it.
interface servo_pwm_decoder_if
    import servo_pkg::*;
#(
    parameter int CNT_W = 21
) ();
    logic             pwm_in;
    angle_t           angle_out;
    logic             angle_valid;
    logic [CNT_W-1:0] width_cyc;
    logic [CNT_W-1:0] period_cyc;
    logic             range_err;
    logic             signal_lost;
    logic             overrun;

    modport master (
        output pwm_in,
        input  angle_out, angle_valid, width_cyc, period_cyc, range_err, signal_lost, overrun
    );

    modport slave (
        input  pwm_in,
        output angle_out, angle_valid, width_cyc, period_cyc, range_err, signal_lost, overrun
    );
endinterface

// File: rtl/servo_pwm_decoder_div.sv
// Clamp + scale + 8-step restoring divide: pulse width to 0..180 degrees, fixed 10-cycle latency.
module servo_angle_div
    import servo_pkg::*;
#(
    parameter int MIN_PULSE_CYC = 50_000,
    parameter int MAX_PULSE_CYC = 100_000,
    parameter int CNT_W         = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] width,
    output logic             busy,
    output angle_t           angle,
    output logic             range_err,
    output logic             valid
);
    localparam int NUM_W = 24;
    localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_PULSE_CYC);
    localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_PULSE_CYC);
    localparam logic [31:0]      SPAN  = 32'(MAX_PULSE_CYC - MIN_PULSE_CYC);

    div_phase_t       phase;
    logic [CNT_W-1:0] w_clamp;
    logic             rerr_p;
    logic [NUM_W-1:0] rem;
    angle_t           quo;
    logic [2:0]       bit_idx;
    logic [31:0]      dshift;

    assign busy   = (phase != DIV_IDLE);
    assign dshift = SPAN << bit_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= DIV_IDLE;
            w_clamp   <= '0;
            rerr_p    <= 1'b0;
            rem       <= '0;
            quo       <= '0;
            bit_idx   <= '0;
            angle     <= '0;
            range_err <= 1'b0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (phase)
                DIV_IDLE: begin
                    if (start) begin
                        if (width < MIN_W) begin
                            w_clamp <= MIN_W;
                            rerr_p  <= 1'b1;
                        end else if (width > MAX_W) begin
                            w_clamp <= MAX_W;
                            rerr_p  <= 1'b1;
                        end else begin
                            w_clamp <= width;
                            rerr_p  <= 1'b0;
                        end
                        phase <= DIV_NUM;
                    end
                end
                DIV_NUM: begin
                    rem     <= NUM_W'(w_clamp - MIN_W) * NUM_W'(ANGLE_MAX);
                    quo     <= '0;
                    bit_idx <= 3'd7;
                    phase   <= DIV_ITER;
                end
                DIV_ITER: begin
                    // Quotient never exceeds 180, so 8 trial subtractions suffice.
                    if ({8'b0, rem} >= dshift) begin
                        rem          <= rem - NUM_W'(dshift);
                        quo[bit_idx] <= 1'b1;
                    end
                    if (bit_idx == 3'd0) phase <= DIV_OUT;
                    else                 bit_idx <= bit_idx - 3'd1;
                end
                DIV_OUT: begin
                    angle     <= quo;
                    range_err <= rerr_p;
                    valid     <= 1'b1;
                    phase     <= DIV_IDLE;
                end
                default: phase <= DIV_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: synchronise, measure high width and period, watch for loss, decode angle.
//   state   | meaning
//   ST_IDLE | no measurement; waiting for a clean rising edge
//   ST_HIGH | line high, width counter running
//   ST_LOW  | line low after a pulse, waiting for the next rise
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int MIN_PULSE_CYC = 50_000,
    parameter int MAX_PULSE_CYC = 100_000,
    parameter int TIMEOUT_CYC   = 1_250_000,
    parameter int CNT_W         = 21,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                clk,
    input  logic                rst,
    servo_pwm_decoder_if.slave  bus
);
    localparam int               TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // The synchroniser is deliberately not reset so a line already high at reset shows no edge.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_d;
    logic                   rise, fall, timeout;
    state_t                 state;
    logic [CNT_W-1:0]       width_cnt, period_cnt, width_q, period_q;
    logic [TO_W-1:0]        to_cnt;
    logic                   lost_q, overrun_q;
    logic                   div_start, div_busy, div_valid, div_rerr;
    angle_t                 div_angle;

    always_ff @(posedge clk) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
        pwm_d  <= sync_q[SYNC_STAGES-1];
    end

    assign rise      = sync_q[SYNC_STAGES-1] & ~pwm_d;
    assign fall      = ~sync_q[SYNC_STAGES-1] & pwm_d;
    assign timeout   = (to_cnt == TO_LAST) & ~rise;
    assign div_start = (state == ST_HIGH) & fall & ~div_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            width_cnt  <= '0;
            period_cnt <= '0;
            to_cnt     <= '0;
            width_q    <= '0;
            period_q   <= '0;
            lost_q     <= 1'b1;
            overrun_q  <= 1'b0;
        end else begin
            if (rise)                      period_cnt <= CNT_ONE;
            else if (period_cnt != CNT_SAT) period_cnt <= period_cnt + CNT_ONE;

            if (rise)                   to_cnt <= '0;
            else if (to_cnt != TO_LAST) to_cnt <= to_cnt + TO_W'(1);

            if (div_valid) lost_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        width_cnt <= CNT_ONE;
                        state     <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        width_q <= width_cnt;
                        if (div_busy) overrun_q <= 1'b1;
                        state <= ST_LOW;
                    end else if (width_cnt != CNT_SAT) begin
                        width_cnt <= width_cnt + CNT_ONE;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        period_q  <= period_cnt;
                        width_cnt <= CNT_ONE;
                        state     <= ST_HIGH;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (timeout) begin
                lost_q <= 1'b1;
                state  <= ST_IDLE;
            end
        end
    end

    servo_angle_div #(
        .MIN_PULSE_CYC (MIN_PULSE_CYC),
        .MAX_PULSE_CYC (MAX_PULSE_CYC),
        .CNT_W         (CNT_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .width     (width_cnt),
        .busy      (div_busy),
        .angle     (div_angle),
        .range_err (div_rerr),
        .valid     (div_valid)
    );

    assign bus.angle_out   = div_angle;
    assign bus.angle_valid = div_valid;
    assign bus.range_err   = div_rerr;
    assign bus.width_cyc   = width_q;
    assign bus.period_cyc  = period_q;
    assign bus.signal_lost = lost_q;
    assign bus.overrun     = overrun_q;
endmodule
